// File: rtl/laser_dac_pkg.sv
// Shared types and default timing for the galvo DAC serial transmitters.
package laser_dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_tx_state_t;

  localparam int DAC_CLK_DIV  = 4;
  localparam int DAC_CS_SETUP = 2;
  localparam int DAC_CS_HOLD  = 2;
  localparam int DAC_CS_IDLE  = 2;
  localparam int DAC_WORD_LEN = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter: ticks every RELOAD cycles while enabled, or once after
// a loaded count; used for SCLK half-periods and the CS setup/hold/idle windows.
module spi_half_period_timer #(
  parameter int W      = 3,
  parameter int RELOAD = 4
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tick
);

  localparam logic [W-1:0] ONE        = W'(1);
  localparam logic [W-1:0] RELOAD_CNT = W'(RELOAD - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val - ONE;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? RELOAD_CNT : r_cnt - ONE;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_dac_tx.sv
// SPI mode-0 frame transmitter for one galvo DAC axis.
// Optional SPI_DAC_TX_LDAC_EN adds an active-low ldac_out pulsed during the CS idle gap.
module spi_dac_tx
  import laser_dac_pkg::*;
#(
  parameter int MAX_LEN  = DAC_WORD_LEN,
  parameter int CLK_DIV  = DAC_CLK_DIV,
  parameter int CS_SETUP = DAC_CS_SETUP,
  parameter int CS_HOLD  = DAC_CS_HOLD,
  parameter int CS_IDLE  = DAC_CS_IDLE
)(
  input  logic                           clock_in,
  input  logic                           reset_n_in,
  input  logic [MAX_LEN-1:0]             data_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]   data_length_in,
  input  logic                           start_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           sclk_out,
  output logic                           mosi_out,
`ifdef SPI_DAC_TX_LDAC_EN
  output logic                           cs_out,
  output logic                           ldac_out
`else
  output logic                           cs_out
`endif
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_IDLE));
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_LW   = LW'(1);

  spi_tx_state_t      r_state, w_state_next;
  logic               r_cs, w_cs_next;
  logic               r_sclk, w_sclk_next;
  logic               r_mosi, w_mosi_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic [MAX_LEN-1:0] r_shift, w_shift_next;
  logic [LW-1:0]      r_bits, w_bits_next;

  logic               w_tmr_en, w_tmr_load, w_tick;
  logic [TW-1:0]      w_tmr_val;
  logic [LW-1:0]      w_len_eff;
  logic [MAX_LEN-1:0] w_aligned;

  // Out-of-range lengths send a full word; the word is left-justified so the
  // shift register always emits from its top bit.
  assign w_len_eff = (data_length_in == '0 || data_length_in > FULL_LEN) ? FULL_LEN : data_length_in;
  assign w_aligned = data_in << (FULL_LEN - w_len_eff);

  spi_half_period_timer #(
    .W      (TW),
    .RELOAD (CLK_DIV)
  ) u_timer (
    .i_clk      (clock_in),
    .i_rst_n    (reset_n_in),
    .i_en       (w_tmr_en),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= IDLE;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cs    <= w_cs_next;
      r_sclk  <= w_sclk_next;
      r_mosi  <= w_mosi_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_shift <= w_shift_next;
      r_bits  <= w_bits_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cs_next    = r_cs;
    w_sclk_next  = r_sclk;
    w_mosi_next  = r_mosi;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_shift_next = r_shift;
    w_bits_next  = r_bits;
    w_tmr_en     = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_state_next = SETUP;
          w_cs_next    = 1'b0;
          w_busy_next  = 1'b1;
          w_shift_next = w_aligned;
          w_mosi_next  = w_aligned[MAX_LEN-1];
          w_bits_next  = w_len_eff - ONE_LW;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(CS_SETUP);
        end
      end
      SETUP: begin
        w_tmr_en = 1'b1;
        if (w_tick) w_state_next = SHIFT;
      end
      SHIFT: begin
        w_tmr_en = 1'b1;
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_next = 1'b1;
          end else if (r_bits == '0) begin
            w_state_next = HOLD;
            w_sclk_next  = 1'b0;
            w_tmr_load   = 1'b1;
            w_tmr_val    = TW'(CS_HOLD);
          end else begin
            w_sclk_next  = 1'b0;
            w_shift_next = r_shift << 1;
            w_mosi_next  = r_shift[MAX_LEN-2];
            w_bits_next  = r_bits - ONE_LW;
          end
        end
      end
      HOLD: begin
        w_tmr_en = 1'b1;
        if (w_tick) begin
          w_cs_next   = 1'b1;
          w_mosi_next = 1'b0;
          if (CS_IDLE > 0) begin
            w_state_next = GAP;
            w_tmr_load   = 1'b1;
            w_tmr_val    = TW'(CS_IDLE);
          end else begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end
      end
      GAP: begin
        w_tmr_en = 1'b1;
        if (w_tick) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign cs_out   = r_cs;
  assign sclk_out = r_sclk;
  assign mosi_out = r_mosi;
  assign busy_out = r_busy;
  assign done_out = r_done;

`ifdef SPI_DAC_TX_LDAC_EN
  logic r_ldac;

  if (CS_IDLE < 1) begin : g_ldac_idle_check
    $error("spi_dac_tx: CS_IDLE must be at least 1 when ldac_out is enabled");
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) r_ldac <= 1'b1;
    else             r_ldac <= (w_state_next != GAP);
  end

  assign ldac_out = r_ldac;
`endif

endmodule

// File: tb/tb_spi_dac_tx.sv
// Self-checking bench for spi_dac_tx: table vectors, random frames against a
// frame-level model, back-to-back, ignored start and mid-frame reset sequences.
module tb_spi_dac_tx;

  localparam int D = 4;
  localparam int S = 2;
  localparam int H = 2;
  localparam int I = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [4:0]  len = '0;
  logic        start = 1'b0;
  logic        busy, done, sclk, mosi, cs;
`ifdef SPI_DAC_TX_LDAC_EN
  logic        ldac;
`endif

  always #5 clk = ~clk;

  spi_dac_tx dut (
    .clock_in       (clk),
    .reset_n_in     (rst_n),
    .data_in        (data),
    .data_length_in (len),
    .start_in       (start),
    .busy_out       (busy),
    .done_out       (done),
    .sclk_out       (sclk),
    .mosi_out       (mosi),
`ifdef SPI_DAC_TX_LDAC_EN
    .cs_out         (cs),
    .ldac_out       (ldac)
`else
    .cs_out         (cs)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  logic cap_bits [0:4095];
  int   rise_cyc [0:4095];
  int   busy_rise [0:127];
  int   done_cyc [0:127];
  int   gap_len [0:127];
  int   rise_total = 0, busy_total = 0, done_total = 0;
  int   n_busy = 0, n_gap = 0, high_run = 0, stray = 0, ldac_low = 0;
  logic prev_sclk = 1'b0, prev_busy = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_busy <= busy;
    prev_cs   <= cs;
    if (sclk && !prev_sclk) begin
      cap_bits[rise_total] <= mosi;
      rise_cyc[rise_total] <= cyc;
      rise_total <= rise_total + 1;
    end
    if (busy) busy_total <= busy_total + 1;
    if (busy && !prev_busy) begin
      busy_rise[n_busy] <= cyc;
      n_busy <= n_busy + 1;
    end
    if (done) begin
      done_cyc[done_total] <= cyc;
      done_total <= done_total + 1;
    end
    if (cs) high_run <= high_run + 1;
    else if (prev_cs) begin
      gap_len[n_gap] <= high_run;
      n_gap <= n_gap + 1;
      high_run <= 0;
    end
    if (cs && (mosi || sclk)) stray <= stray + 1;
`ifdef SPI_DAC_TX_LDAC_EN
    if (!ldac) ldac_low <= ldac_low + 1;
`endif
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: effective length, expected word and busy width.
  function automatic int model_len(input int l);
    return (l == 0 || l > 16) ? 16 : l;
  endfunction

  function automatic int model_busy(input int l);
    return S + 2 * D * model_len(l) + H + I;
  endfunction

  function automatic int collect(input int from, input int count);
    int v = 0;
    for (int k = 0; k < count && k < 32; k++) v = (v << 1) | int'(cap_bits[from + k]);
    return v;
  endfunction

  task automatic do_frame(input string name, input logic [15:0] d, input logic [4:0] l,
                          input int exp_rises, input int exp_cap, input int exp_busy,
                          input int inject_at);
    int  r0, b0, d0, l0, nb0, t0, dc;
    bit  got;
    r0 = rise_total; b0 = busy_total; d0 = done_total; l0 = ldac_low; nb0 = n_busy;
    got = 1'b0; dc = 0;
    @(negedge clk);
    data = d; len = l; start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    data = ~d;
    for (int i = 1; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        dc = cyc;
        break;
      end
      if (i == inject_at) begin
        data = 16'hFFFF;
        start = 1'b1;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, ".done_seen"}, got, 1);
    chk({name, ".done_at"}, dc - t0, exp_busy);
    repeat (6) @(negedge clk);
    #1;
    chk({name, ".rises"}, rise_total - r0, exp_rises);
    chk({name, ".captured"}, collect(r0, rise_total - r0), exp_cap);
    chk({name, ".busy_cycles"}, busy_total - b0, exp_busy);
    chk({name, ".done_pulses"}, done_total - d0, 1);
    chk({name, ".busy_start"}, busy_rise[nb0] - t0, 0);
    chk({name, ".first_rise"}, rise_cyc[r0] - t0, S + D);
`ifdef SPI_DAC_TX_LDAC_EN
    chk({name, ".ldac_low"}, ldac_low - l0, I);
`endif
    $display("frame %s data=%h len=%0d rises=%0d cap=%h busy=%0d", name, d, l,
             rise_total - r0, collect(r0, rise_total - r0), busy_total - b0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    int          rises;
    int          cap;
    int          busy;
    int          inject;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, b0, d0, nb0, g0, l0, seen;
    logic [15:0] rd;
    logic [4:0]  rl;
    int          eff;

    vecs[0] = '{16'hA5C3, 5'd16, 16, 'hA5C3, 134, 0};
    vecs[1] = '{16'h0ABC, 5'd12, 12, 'h0ABC, 102, 0};
    vecs[2] = '{16'h0ABC, 5'd0,  16, 'h0ABC, 134, 0};
    vecs[3] = '{16'hFFFF, 5'd1,   1, 'h0001,  14, 0};
    vecs[4] = '{16'h5555, 5'd20, 16, 'h5555, 134, 0};
    vecs[5] = '{16'h0002, 5'd2,   2, 'h0002,  22, 0};
    vecs[6] = '{16'h1234, 5'd16, 16, 'h1234, 134, 40};

    // Reset held with the clock running.
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset.cs", cs, 1);
    chk("reset.sclk", sclk, 0);
    chk("reset.mosi", mosi, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
`ifdef SPI_DAC_TX_LDAC_EN
    chk("reset.ldac", ldac, 1);
`endif
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("idle.no_busy", busy_total, 0);
    chk("idle.no_rises", rise_total, 0);
    chk("idle.cs_high", cs, 1);

    for (int v = 0; v < 7; v++) begin
      do_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].rises,
               vecs[v].cap, vecs[v].busy, vecs[v].inject);
    end

    for (int n = 0; n < 8; n++) begin
      rd  = 16'($urandom);
      rl  = 5'($urandom_range(0, 31));
      eff = model_len(int'(rl));
      do_frame($sformatf("rand%0d", n), rd, rl, eff, int'(rd) & ((1 << eff) - 1),
               model_busy(int'(rl)), 0);
    end

    // Back-to-back: start held high across three frames.
    r0 = rise_total; b0 = busy_total; d0 = done_total; nb0 = n_busy; g0 = n_gap; l0 = ldac_low;
    seen = 0;
    @(negedge clk);
    data = 16'h5A0F; len = 5'd16; start = 1'b1;
    for (int i = 0; i < 3000 && seen < 2; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && seen < 3; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("b2b.done_seen", seen, 3);
    repeat (6) @(negedge clk);
    #1;
    chk("b2b.done_pulses", done_total - d0, 3);
    chk("b2b.rises", rise_total - r0, 48);
    chk("b2b.busy_cycles", busy_total - b0, 3 * model_busy(16));
    chk("b2b.frame3", collect(r0 + 32, 16), 'h5A0F);
    chk("b2b.cs_falls", n_gap - g0, 3);
    // Between frames CS stays high for the idle gap plus the done cycle.
    chk("b2b.cs_gap1", gap_len[g0 + 1], I + 1);
    chk("b2b.cs_gap2", gap_len[g0 + 2], I + 1);
    chk("b2b.restart1", busy_rise[nb0 + 1] - done_cyc[d0], 1);
    chk("b2b.restart2", busy_rise[nb0 + 2] - done_cyc[d0 + 1], 1);
`ifdef SPI_DAC_TX_LDAC_EN
    chk("b2b.ldac_low", ldac_low - l0, 3 * I);
`endif
    $display("frame b2b data=5a0f x3 rises=%0d busy=%0d", rise_total - r0, busy_total - b0);

    // Reset asserted while bit 7 is on the wire.
    r0 = rise_total; l0 = ldac_low; seen = 0;
    @(negedge clk);
    data = 16'hA5C3; len = 5'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (rise_total - r0 >= 9) begin
        seen = 1;
        break;
      end
    end
    chk("abort.reached_bit7", seen, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.cs", cs, 1);
    chk("abort.busy", busy, 0);
    chk("abort.sclk", sclk, 0);
    chk("abort.mosi", mosi, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort.rises", rise_total - r0, 9);
`ifdef SPI_DAC_TX_LDAC_EN
    chk("abort.ldac_low", ldac_low - l0, 0);
`endif
    $display("frame abort data=a5c3 rises=%0d", rise_total - r0);
    do_frame("after_abort", 16'h8001, 5'd16, 16, 'h8001, 134, 0);

    chk("cs_high_quiet", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
